// File: rtl/trigger_pkg.sv
// Shared types and default parameter values for the trigger capture block.
//   trig_mode_e  : trigger mode encoding as seen on the mode input
//   cap_state_e  : capture FSM states
//   DEF_*        : default parameter values for trigger_capture
package trigger_pkg;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'b00,
        TRIG_RISING    = 2'b01,
        TRIG_FALLING   = 2'b10,
        TRIG_LEVEL     = 2'b11
    } trig_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        DONE
    } cap_state_e;

    localparam int DEF_DATA_W   = 12;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_PRE_TRIG = 64;
    localparam int DEF_HYST     = 4;
    localparam int DEF_HOLD_W   = 16;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port capture memory, DEPTH x DATA_W.
//   clk      : system clock
//   rst      : asynchronous active-low reset (read register only, not the array)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : registered read data, one cycle after rd_addr
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/trigger_capture.sv
// Triggered waveform capture: writes the ADC stream into a circular RAM,
// detects an edge/level/immediate trigger with hysteresis, and freezes a
// DEPTH-sample record holding PRE_TRIG samples of pre-trigger history.
//   clk, rst       : system clock, asynchronous active-low reset
//   sample_valid   : qualifies sample_data
//   sample_data    : unsigned ADC sample
//   mode           : 00 immediate, 01 rising, 10 falling, 11 level
//   level          : trigger threshold
//   single         : 1 = hold record until arm, 0 = auto-rearm after holdoff
//   arm            : start pulse, accepted in IDLE and DONE
//   holdoff        : clk cycles spent in DONE before auto-rearm
//   rd_addr        : record index, 0 = oldest sample
//   rd_data        : registered record sample
//   busy           : capture in progress (PRE/WAIT/POST)
//   triggered      : pulse on the accepted trigger sample
//   done           : record complete and stable
//   trig_idx       : record index of the trigger sample
//
// state | meaning
// IDLE  | not armed, RAM untouched
// PRE   | collecting PRE_TRIG samples of history
// WAIT  | writing and looking for the trigger event
// POST  | writing the remainder of the record
// DONE  | record frozen; wait for arm or holdoff expiry
module trigger_capture
    import trigger_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PRE_TRIG = DEF_PRE_TRIG,
    parameter int HYST     = DEF_HYST,
    parameter int HOLD_W   = DEF_HOLD_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] level,
    input  logic              single,
    input  logic              arm,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [AW-1:0]     trig_idx
);

    localparam int            POST_N    = DEPTH - PRE_TRIG - 1;
    localparam logic [AW-1:0] PRE_IDX   = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LOAD  = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_N - 1);
    localparam logic [DATA_W:0] HYST_X  = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0] MAX_X   = {1'b0, {DATA_W{1'b1}}};

    cap_state_e        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     start_ptr_q, start_ptr_d;
    logic [AW-1:0]     trig_idx_q, trig_idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              flag_q, flag_d;
    trig_mode_e        mode_q, mode_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic              lo_sat_q, lo_sat_d;
    logic              hi_sat_q, hi_sat_d;

    logic [DATA_W:0]   level_x;
    logic [DATA_W:0]   hi_x;
    logic              lo_sat_new, hi_sat_new;
    logic [DATA_W-1:0] lo_new, hi_new;
    logic              below_lo, above_hi;
    logic              trig_hit;
    logic              wr_en;
    logic              start;
    logic              trig_pulse;
    logic [AW-1:0]     ram_rd_addr;

    // Hysteresis thresholds in one extra bit so neither side can wrap.
    always_comb begin
        level_x    = {1'b0, level};
        hi_x       = level_x + HYST_X;
        lo_sat_new = (level_x <= HYST_X);
        hi_sat_new = (hi_x >= MAX_X);
        lo_new     = lo_sat_new ? '0 : DATA_W'(level_x - HYST_X);
        hi_new     = hi_sat_new ? '1 : hi_x[DATA_W-1:0];
    end

    // A saturated band can never be strictly exceeded, so the rail value
    // itself arms the edge detector in that case.
    always_comb begin
        below_lo = (sample_data < lo_q) || (lo_sat_q && (sample_data == '0));
        above_hi = (sample_data > hi_q) || (hi_sat_q && (sample_data == '1));
        trig_hit = 1'b0;
        case (mode_q)
            TRIG_IMMEDIATE: trig_hit = 1'b1;
            TRIG_RISING:    trig_hit = flag_q && (sample_data >= level_q);
            TRIG_FALLING:   trig_hit = flag_q && (sample_data <= level_q);
            default:        trig_hit = (sample_data >= level_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        start_ptr_d = start_ptr_q;
        trig_idx_d  = trig_idx_q;
        hold_d      = hold_q;
        flag_d      = flag_q;
        mode_d      = mode_q;
        level_d     = level_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        lo_sat_d    = lo_sat_q;
        hi_sat_d    = hi_sat_q;
        start       = 1'b0;
        trig_pulse  = 1'b0;

        wr_en = sample_valid &&
                ((state_q == PRE) || (state_q == WAIT) || (state_q == POST));
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    start = 1'b1;
                end
            end
            PRE: begin
                if (sample_valid) begin
                    if (cnt_q == '0) begin
                        state_d = WAIT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            WAIT: begin
                if (sample_valid) begin
                    if (trig_hit) begin
                        trig_pulse  = 1'b1;
                        flag_d      = 1'b0;
                        start_ptr_d = wr_ptr_q - PRE_IDX;
                        trig_idx_d  = PRE_IDX;
                        if (POST_N == 0) begin
                            state_d = DONE;
                            hold_d  = holdoff;
                        end else begin
                            state_d = POST;
                            cnt_d   = POST_LOAD;
                        end
                    end else if (((mode_q == TRIG_RISING) && below_lo) ||
                                 ((mode_q == TRIG_FALLING) && above_hi)) begin
                        flag_d = 1'b1;
                    end
                end
            end
            POST: begin
                if (sample_valid) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        hold_d  = holdoff;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (arm) begin
                    start = 1'b1;
                end else if (!single) begin
                    if (hold_q == '0) begin
                        start = 1'b1;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Trigger setup is snapshotted here so mid-capture input changes
        // only affect the next capture.
        if (start) begin
            state_d  = (PRE_TRIG == 0) ? WAIT : PRE;
            cnt_d    = PRE_LOAD;
            hold_d   = '0;
            flag_d   = 1'b0;
            mode_d   = trig_mode_e'(mode);
            level_d  = level;
            lo_d     = lo_new;
            hi_d     = hi_new;
            lo_sat_d = lo_sat_new;
            hi_sat_d = hi_sat_new;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            start_ptr_q <= '0;
            trig_idx_q  <= '0;
            hold_q      <= '0;
            flag_q      <= 1'b0;
            mode_q      <= TRIG_IMMEDIATE;
            level_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            lo_sat_q    <= 1'b0;
            hi_sat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            start_ptr_q <= start_ptr_d;
            trig_idx_q  <= trig_idx_d;
            hold_q      <= hold_d;
            flag_q      <= flag_d;
            mode_q      <= mode_d;
            level_q     <= level_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            lo_sat_q    <= lo_sat_d;
            hi_sat_q    <= hi_sat_d;
        end
    end

    assign ram_rd_addr = start_ptr_q + rd_addr;

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (sample_data),
        .rd_addr (ram_rd_addr),
        .rd_data (rd_data)
    );

    assign busy      = (state_q == PRE) || (state_q == WAIT) || (state_q == POST);
    assign done      = (state_q == DONE);
    assign triggered = trig_pulse;
    assign trig_idx  = trig_idx_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture: a default instance (DEPTH 256,
// PRE_TRIG 64) and a small one (DEPTH 16, PRE_TRIG 0) share the sample bus.
module tb_trigger_capture;

    localparam int HY = 4;
    localparam int P0 = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [1:0]  mode;
    logic [11:0] level;
    logic        single;
    logic [15:0] holdoff;
    logic        arm0, arm1;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data0, rd_data1;
    logic        busy0, busy1, trig0, trig1, done0, done1;
    logic [7:0]  trig_idx0;
    logic [3:0]  trig_idx1;
    logic        sel;

    always #5 clk = ~clk;

    trigger_capture #(.DATA_W(12), .DEPTH(256), .PRE_TRIG(64), .HYST(4), .HOLD_W(16)) dut0 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .mode(mode), .level(level), .single(single), .arm(arm0), .holdoff(holdoff),
        .rd_addr(rd_addr), .rd_data(rd_data0), .busy(busy0), .triggered(trig0),
        .done(done0), .trig_idx(trig_idx0)
    );

    trigger_capture #(.DATA_W(12), .DEPTH(16), .PRE_TRIG(0), .HYST(4), .HOLD_W(16)) dut1 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .mode(mode), .level(level), .single(single), .arm(arm1), .holdoff(holdoff),
        .rd_addr(rd_addr[3:0]), .rd_data(rd_data1), .busy(busy1), .triggered(trig1),
        .done(done1), .trig_idx(trig_idx1)
    );

    logic done_s, busy_s, trig_s;
    assign done_s = sel ? done1 : done0;
    assign busy_s = sel ? busy1 : busy0;
    assign trig_s = sel ? trig1 : trig0;

    int stim[$];
    int rec[256];
    int pos, cap_start, trig_at, trig_cnt;
    int checks = 0;
    int failures = 0;

    // Reference: index in stim of the sample that should trigger, scanning
    // the valid sample sequence after the pre-trigger history.
    function automatic int model_trig(int start, int md, int lvl, int pre);
        int lo, hi;
        bit lo_sat, hi_sat, armed;
        lo = (lvl - HY < 0) ? 0 : lvl - HY;
        hi = (lvl + HY > 4095) ? 4095 : lvl + HY;
        lo_sat = (lvl - HY <= 0);
        hi_sat = (lvl + HY >= 4095);
        armed = 0;
        for (int i = start + pre; i < stim.size(); i++) begin
            int s;
            s = stim[i];
            case (md)
                0: return i;
                3: if (s >= lvl) return i;
                1: begin
                    if (armed && s >= lvl) return i;
                    if (s < lo || (lo_sat && s == 0)) armed = 1;
                end
                default: begin
                    if (armed && s <= lvl) return i;
                    if (s > hi || (hi_sat && s == 4095)) armed = 1;
                end
            endcase
        end
        return -1;
    endfunction

    task automatic arm_pulse();
        @(posedge clk); #1;
        sample_valid = 0;
        if (sel) arm1 = 1; else arm0 = 1;
        @(posedge clk); #1;
        arm0 = 0;
        arm1 = 0;
    endtask

    // Streams stim[pos..] until done, a cycle budget, or stop_after samples
    // past the trigger. Records triggered pulses; makes no comparisons.
    task automatic feed(input int max_cyc, input bit toggle, input int stop_after, input int arm_at);
        trig_cnt = 0;
        trig_at = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk); #1;
            arm0 = 0;
            arm1 = 0;
            if (c == arm_at) begin
                if (sel) arm1 = 1; else arm0 = 1;
            end
            if ((!toggle || (c % 2 == 0)) && pos < stim.size()) begin
                sample_valid = 1;
                sample_data = 12'(stim[pos]);
            end else begin
                sample_valid = 0;
                sample_data = 12'($urandom);
            end
            @(negedge clk);
            if (done_s) begin
                sample_valid = 0;
                arm0 = 0;
                arm1 = 0;
                return;
            end
            if (sample_valid && busy_s) begin
                if (trig_s) begin
                    trig_cnt++;
                    trig_at = pos;
                end
                pos++;
            end
            if (trig_at >= 0 && stop_after >= 0 && pos - trig_at > stop_after) begin
                sample_valid = 0;
                arm0 = 0;
                return;
            end
        end
        sample_valid = 0;
        arm0 = 0;
        arm1 = 0;
    endtask

    task automatic read_record(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 8'(i);
            @(posedge clk);
            @(negedge clk);
            rec[i] = sel ? int'(rd_data1) : int'(rd_data0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (trig0 !== 1'b0) begin failures++; $display("FAIL reset_triggered: got %b expected 0", trig0); end
        checks++; if (trig_idx0 !== 8'd0) begin failures++; $display("FAIL reset_trig_idx: got %0d expected 0", trig_idx0); end
        checks++; if (rd_data0 !== 12'd0) begin failures++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data0); end
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_small: got busy=%b done=%b expected 0 0", busy1, done1); end
        rst = 1;
        repeat (3) @(negedge clk);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL idle_no_arm: got busy=%b expected 0", busy0); end
    endtask

    task automatic test_rising_ramp();
        int exp_t, bad, first;
        stim.delete();
        for (int v = 0; v < 4096; v += 8) stim.push_back(v);
        pos = 0; sel = 0; mode = 2'b01; level = 12'd2000; single = 1; holdoff = 0;
        arm_pulse();
        cap_start = pos;
        feed(2000, 0, -1, 100);
        exp_t = model_trig(cap_start, 1, 2000, P0);
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL ramp_done: got %b expected 1", done0); end
        checks++; if (trig_cnt !== 1) begin failures++; $display("FAIL ramp_trig_count: got %0d expected 1", trig_cnt); end
        checks++; if (trig_at !== exp_t) begin failures++; $display("FAIL ramp_trig_pos: got %0d expected %0d", trig_at, exp_t); end
        checks++; if (trig_idx0 !== 8'd64) begin failures++; $display("FAIL ramp_trig_idx: got %0d expected 64", trig_idx0); end
        read_record(256);
        checks++; if (rec[64] !== 2000) begin failures++; $display("FAIL ramp_rec64: got %0d expected 2000", rec[64]); end
        checks++; if (rec[0] !== 1488) begin failures++; $display("FAIL ramp_rec0: got %0d expected 1488", rec[0]); end
        checks++; if (rec[255] !== 3528) begin failures++; $display("FAIL ramp_rec255: got %0d expected 3528", rec[255]); end
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) begin
            if (rec[i] !== stim[exp_t - P0 + i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL ramp_record: %0d bad entries, first idx %0d got %0d expected %0d",
                     bad, first, rec[first], stim[exp_t - P0 + first]);
        end
    endtask

    task automatic test_noise_hyst();
        int exp_t;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(int'($urandom_range(1000, 0)));
        stim.push_back(1998); stim.push_back(2001); stim.push_back(1999);
        stim.push_back(2002); stim.push_back(1990); stim.push_back(2005);
        for (int i = 0; i < 220; i++) stim.push_back(int'($urandom_range(4095, 0)));
        pos = 0; sel = 0; mode = 2'b01; level = 12'd2000; single = 1;
        arm_pulse();
        // Changed after arming: must not affect this capture.
        mode = 2'b11; level = 12'd100;
        cap_start = pos;
        feed(2000, 0, -1, -1);
        exp_t = model_trig(cap_start, 1, 2000, P0);
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL noise_done: got %b expected 1", done0); end
        checks++; if (trig_cnt !== 1) begin failures++; $display("FAIL noise_trig_count: got %0d expected 1", trig_cnt); end
        checks++; if (trig_at !== exp_t) begin failures++; $display("FAIL noise_trig_pos: got %0d expected %0d", trig_at, exp_t); end
    endtask

    task automatic test_falling_holdoff();
        int exp_t, n;
        stim.delete();
        for (int k = 0; k < 1500; k++)
            stim.push_back(int'(2000.0 + 1900.0 * $sin(6.2831853 * k / 57.0)));
        pos = 0; sel = 0; mode = 2'b10; level = 12'd1000; single = 0; holdoff = 16'd20;
        rd_addr = 8'd64;
        arm_pulse();
        for (int cap = 0; cap < 3; cap++) begin
            cap_start = pos;
            feed(1000, 0, -1, -1);
            exp_t = model_trig(cap_start, 2, 1000, P0);
            checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL sine_done cap %0d: got %b expected 1", cap, done0); end
            checks++; if (trig_cnt !== 1) begin failures++; $display("FAIL sine_trig_count cap %0d: got %0d expected 1", cap, trig_cnt); end
            checks++; if (trig_at !== exp_t) begin failures++; $display("FAIL sine_trig_pos cap %0d: got %0d expected %0d", cap, trig_at, exp_t); end
            if (cap == 2) begin
                single = 1;
                break;
            end
            n = 1;
            for (int w = 0; w < 100; w++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (!done0) break;
                n++;
                if (n == 2) begin
                    checks++;
                    if (rd_data0 !== 12'(stim[exp_t])) begin
                        failures++;
                        $display("FAIL sine_trig_sample cap %0d: got %0d expected %0d", cap, rd_data0, stim[exp_t]);
                    end
                    checks++; if (trig_idx0 !== 8'd64) begin failures++; $display("FAIL sine_trig_idx cap %0d: got %0d expected 64", cap, trig_idx0); end
                end
            end
            checks++; if (n !== 21) begin failures++; $display("FAIL sine_done_len cap %0d: got %0d expected 21", cap, n); end
        end
    endtask

    task automatic test_saturation();
        int exp_t;
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(0);
        stim.push_back(5); stim.push_back(3); stim.push_back(1); stim.push_back(2);
        stim.push_back(4); stim.push_back(1); stim.push_back(3); stim.push_back(0);
        stim.push_back(1); stim.push_back(2);
        for (int i = 0; i < 200; i++) stim.push_back(int'($urandom_range(4095, 0)));
        pos = 0; sel = 0; mode = 2'b01; level = 12'd2; single = 1;
        arm_pulse();
        cap_start = pos;
        feed(2000, 0, -1, -1);
        exp_t = model_trig(cap_start, 1, 2, P0);
        checks++; if (done0 !== 1'b1 || trig_cnt !== 1) begin failures++; $display("FAIL sat_rise_done: got done=%b count=%0d expected 1 1", done0, trig_cnt); end
        checks++; if (trig_at !== exp_t) begin failures++; $display("FAIL sat_rise_pos: got %0d expected %0d", trig_at, exp_t); end

        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(4095);
        stim.push_back(4093); stim.push_back(4000); stim.push_back(10);
        stim.push_back(4094); stim.push_back(4090); stim.push_back(4095);
        stim.push_back(4094);
        for (int i = 0; i < 200; i++) stim.push_back(int'($urandom_range(4095, 0)));
        pos = 0; mode = 2'b10; level = 12'd4094;
        arm_pulse();
        cap_start = pos;
        feed(2000, 0, -1, -1);
        exp_t = model_trig(cap_start, 2, 4094, P0);
        checks++; if (done0 !== 1'b1 || trig_cnt !== 1) begin failures++; $display("FAIL sat_fall_done: got done=%b count=%0d expected 1 1", done0, trig_cnt); end
        checks++; if (trig_at !== exp_t) begin failures++; $display("FAIL sat_fall_pos: got %0d expected %0d", trig_at, exp_t); end
    endtask

    task automatic test_immediate_gapped();
        int bad, first;
        stim.delete();
        for (int i = 0; i < 100; i++) stim.push_back(int'($urandom_range(4095, 0)));
        pos = 0; sel = 1; mode = 2'b00; single = 1;
        arm_pulse();
        cap_start = pos;
        feed(500, 1, -1, -1);
        checks++; if (done1 !== 1'b1 || trig_cnt !== 1) begin failures++; $display("FAIL imm_done: got done=%b count=%0d expected 1 1", done1, trig_cnt); end
        checks++; if (trig_at !== model_trig(cap_start, 0, 0, 0)) begin failures++; $display("FAIL imm_trig_pos: got %0d expected %0d", trig_at, cap_start); end
        checks++; if (trig_idx1 !== 4'd0) begin failures++; $display("FAIL imm_trig_idx: got %0d expected 0", trig_idx1); end
        read_record(16);
        bad = 0; first = 0;
        for (int i = 0; i < 16; i++) begin
            if (rec[i] !== stim[cap_start + i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL imm_record: %0d bad entries, first idx %0d got %0d expected %0d",
                     bad, first, rec[first], stim[cap_start + first]);
        end
        sel = 0;
    endtask

    task automatic test_reset_mid_post();
        int exp_t, bad, first;
        stim.delete();
        for (int v = 0; v < 4096; v += 8) stim.push_back(v);
        pos = 0; sel = 0; mode = 2'b01; level = 12'd2000; single = 1;
        arm_pulse();
        feed(2000, 0, 20, -1);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_pre_busy: got %b expected 1", busy0); end
        #2 rst = 0;
        #1;
        checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL rst_abort: got busy=%b done=%b expected 0 0", busy0, done0); end
        checks++; if (trig_idx0 !== 8'd0) begin failures++; $display("FAIL rst_trig_idx: got %0d expected 0", trig_idx0); end
        @(negedge clk);
        rst = 1;
        pos = 0;
        arm_pulse();
        cap_start = pos;
        feed(2000, 0, -1, -1);
        exp_t = model_trig(cap_start, 1, 2000, P0);
        checks++; if (done0 !== 1'b1 || trig_cnt !== 1) begin failures++; $display("FAIL rst_recap_done: got done=%b count=%0d expected 1 1", done0, trig_cnt); end
        checks++; if (trig_at !== exp_t) begin failures++; $display("FAIL rst_recap_pos: got %0d expected %0d", trig_at, exp_t); end
        read_record(256);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) begin
            if (rec[i] !== stim[exp_t - P0 + i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_recap_record: %0d bad entries, first idx %0d got %0d expected %0d",
                     bad, first, rec[first], stim[exp_t - P0 + first]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 0; sample_valid = 0; sample_data = 0; mode = 0; level = 0;
        single = 1; holdoff = 0; arm0 = 0; arm1 = 0; rd_addr = 0; sel = 0;
        pos = 0; cap_start = 0; trig_at = -1; trig_cnt = 0;
        repeat (3) @(posedge clk);
        test_reset();
        test_rising_ramp();
        test_noise_hyst();
        test_falling_holdoff();
        test_saturation();
        test_immediate_gapped();
        test_reset_mid_post();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
